// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th enabled integrator sample and runs it
// through N pipelined comb stages (y = x - x delayed by M decimated samples).
module cic_comb_decimator #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 22,
  parameter int R     = 8,
  parameter int N     = 3,
  parameter int M     = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  data_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o
);

  localparam int CNT_W = $clog2(R);

  // valid_o is a one-cycle pulse with no backpressure: data_o is meaningful on
  // the pulse cycle and simply holds its last value in between.

  logic [CNT_W-1:0] dec_cnt_q;
  logic [N:0]       stb_q;
  logic [IN_W-1:0]  stage_q [0:N];
  logic [IN_W-1:0]  dly_q   [1:N][0:M-1];
  logic             take;

  assign take = en_i && (dec_cnt_q == CNT_W'(R - 1));

  // stage_q[0] is the captured sample; stage_q[k] is comb output k, which is
  // updated when the strobe for its input (stb_q[k-1]) arrives.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dec_cnt_q <= '0;
      stb_q     <= '0;
      for (int k = 0; k <= N; k++) stage_q[k] <= '0;
      for (int k = 1; k <= N; k++)
        for (int j = 0; j < M; j++) dly_q[k][j] <= '0;
    end else begin
      if (en_i) dec_cnt_q <= take ? '0 : dec_cnt_q + CNT_W'(1);
      stb_q <= {stb_q[N-1:0], take};
      if (take) stage_q[0] <= data_i;
      for (int k = 1; k <= N; k++) begin
        if (stb_q[k-1]) begin
          // Modulo-2^IN_W subtraction; the wrap is what makes the CIC exact.
          stage_q[k]  <= stage_q[k-1] - dly_q[k][M-1];
          dly_q[k][0] <= stage_q[k-1];
          for (int j = 1; j < M; j++) dly_q[k][j] <= dly_q[k][j-1];
        end
      end
    end
  end

  assign valid_o = stb_q[N];
  assign data_o  = stage_q[N][IN_W-1 -: OUT_W];

endmodule
